// File: rtl/bp_me_mem_cmd_arbiter.sv
// Round-robin arbiter sharing one memory cmd/resp port among num_req_p requesters; zero-cycle cmd and resp paths.
// Backpressure: grants stop while the ID FIFO is full and responses stall until the owner yumis.
// Optional sticky error flag and response checks under BP_ME_MEM_ARB_ERR_CHECK_EN.
module bp_me_mem_cmd_arbiter #(
  parameter int num_req_p     = 2,
  parameter int msg_width_p   = 64,
  parameter int id_fifo_els_p = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic [num_req_p*msg_width_p-1:0] req_cmd_i,
  input  logic [num_req_p-1:0]           req_cmd_v_i,
  output logic [num_req_p-1:0]           req_cmd_ready_and_o,
  output logic [msg_width_p-1:0]         req_resp_o,
  output logic [num_req_p-1:0]           req_resp_v_o,
  input  logic [num_req_p-1:0]           req_resp_yumi_i,
  output logic [msg_width_p-1:0]         mem_cmd_o,
  output logic                           mem_cmd_v_o,
  input  logic                           mem_cmd_ready_and_i,
  input  logic [msg_width_p-1:0]         mem_resp_i,
  input  logic                           mem_resp_v_i,
  output logic                           mem_resp_yumi_o,
  output logic                           error_o
);

  localparam int lg_req_lp = $clog2(num_req_p);
  localparam int lg_els_lp = $clog2(id_fifo_els_p);

  logic [lg_req_lp-1:0] rr_ptr_r, win, head;
  logic                 found;
  logic [lg_req_lp-1:0] id_mem_r [id_fifo_els_p];
  logic [lg_els_lp-1:0] wr_ptr_r, rd_ptr_r;
  logic [lg_els_lp:0]   count_r;
  logic                 fifo_full, fifo_empty, cmd_accept, resp_v, resp_pop;

  assign fifo_full  = (count_r == (lg_els_lp+1)'(id_fifo_els_p));
  assign fifo_empty = (count_r == '0);

  // First valid at or after rr_ptr_r, wrapping modulo num_req_p.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < num_req_p; k++) begin
      int idx;
      idx = (int'(rr_ptr_r) + k) % num_req_p;
      if (!found && req_cmd_v_i[idx]) begin
        found = 1'b1;
        win   = idx[lg_req_lp-1:0];
      end
    end
  end

  assign mem_cmd_v_o = reset_n_i & found & ~fifo_full;
  assign mem_cmd_o   = req_cmd_i[win*msg_width_p +: msg_width_p];
  assign cmd_accept  = mem_cmd_v_o & mem_cmd_ready_and_i;

  always_comb begin
    req_cmd_ready_and_o      = '0;
    req_cmd_ready_and_o[win] = cmd_accept;
  end

  assign head            = id_mem_r[rd_ptr_r];
  assign resp_v          = reset_n_i & mem_resp_v_i & ~fifo_empty;
  assign req_resp_o      = mem_resp_i;
  assign mem_resp_yumi_o = resp_v & req_resp_yumi_i[head];
  assign resp_pop        = mem_resp_yumi_o;

  always_comb begin
    req_resp_v_o       = '0;
    req_resp_v_o[head] = resp_v;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_ptr_r <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (cmd_accept) begin
        rr_ptr_r <= (int'(win) == num_req_p-1) ? '0 : win + 1'b1;
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (resp_pop)
        rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({cmd_accept, resp_pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // ID storage needs no reset: entries are only read while the count covers them.
  always_ff @(posedge clk_i) begin
    if (cmd_accept)
      id_mem_r[wr_ptr_r] <= win;
  end

`ifdef BP_ME_MEM_ARB_ERR_CHECK_EN
  logic error_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      error_r <= 1'b0;
    else if (mem_resp_v_i & fifo_empty)
      error_r <= 1'b1;
  end

  assign error_o = error_r;

  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(mem_resp_v_i && fifo_empty))
        else $error("memory response with no outstanding command");
      assert ((req_resp_yumi_i & ~req_resp_v_o) == '0)
        else $error("yumi from a requester without a valid response");
    end
  end
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
// Directed plus random stimulus against a queue-based model of the arbiter.
module tb_bp_me_mem_cmd_arbiter;

  localparam int N = 2;
  localparam int W = 16;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] req_cmd = '0;
  logic [N-1:0]   req_cmd_v = '0;
  logic [N-1:0]   ready_and;
  logic [W-1:0]   resp_o;
  logic [N-1:0]   resp_v;
  logic [N-1:0]   ry = '0;
  logic [W-1:0]   cmd_o;
  logic           cmd_v;
  logic           mem_rdy = 1'b0;
  logic [W-1:0]   mem_resp = '0;
  logic           mem_resp_v = 1'b0;
  logic           yumi;
  logic           err;

  int n_vec = 0;
  int n_err = 0;
  int ptr = 0;
  int q[$];
  bit err_m = 1'b0;

  bp_me_mem_cmd_arbiter #(
    .num_req_p(N), .msg_width_p(W), .id_fifo_els_p(D)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .req_cmd_i(req_cmd), .req_cmd_v_i(req_cmd_v), .req_cmd_ready_and_o(ready_and),
    .req_resp_o(resp_o), .req_resp_v_o(resp_v), .req_resp_yumi_i(ry),
    .mem_cmd_o(cmd_o), .mem_cmd_v_o(cmd_v), .mem_cmd_ready_and_i(mem_rdy),
    .mem_resp_i(mem_resp), .mem_resp_v_i(mem_resp_v), .mem_resp_yumi_o(yumi),
    .error_o(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] owner_mask();
    logic [N-1:0] m;
    m = '0;
    if (q.size() > 0) m[q[0]] = 1'b1;
    return m;
  endfunction

  function automatic bit have();
    return q.size() > 0;
  endfunction

  task automatic reset_model();
    q.delete();
    ptr   = 0;
    err_m = 1'b0;
  endtask

  // One cycle: drive after negedge, check combinational outputs, advance model at posedge.
  // want: -2 no directed grant check, -1 expect no grant, else expected granted requester.
  task automatic apply(input logic [N-1:0] cv, input logic rdy, input logic rv,
                       input logic [N-1:0] yv, input int want);
    int w;
    bit full, was_empty, e_cv, e_yumi;
    logic [N-1:0] e_rdy, e_rv;
    logic [31:0] gexp;
    req_cmd_v  = cv;
    mem_rdy    = rdy;
    mem_resp_v = rv;
    ry         = yv;
    for (int i = 0; i < N; i++) req_cmd[i*W +: W] = W'($urandom);
    mem_resp = W'($urandom);
    #1;
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && cv[(ptr+k)%N]) w = (ptr+k)%N;
    full      = (q.size() >= D);
    was_empty = (q.size() == 0);
    e_cv      = rst_n && (w >= 0) && !full;
    e_rdy     = '0;
    if (e_cv && rdy) e_rdy[w] = 1'b1;
    e_rv = '0;
    if (rst_n && rv && !was_empty) e_rv[q[0]] = 1'b1;
    e_yumi = 1'b0;
    if (e_rv != '0) e_yumi = yv[q[0]];

    check("cmd_v", 32'(cmd_v), 32'(e_cv));
    check("ready_and", 32'(ready_and), 32'(e_rdy));
    if (e_cv) check("cmd_data", 32'(cmd_o), 32'(req_cmd[w*W +: W]));
    check("resp_v", 32'(resp_v), 32'(e_rv));
    check("resp_data", 32'(resp_o), 32'(mem_resp));
    check("mem_yumi", 32'(yumi), 32'(e_yumi));
    check("error", 32'(err), 32'(err_m));
    if (want != -2) begin
      gexp = (want >= 0) ? (32'd1 << want) : 32'd0;
      check("grant", 32'(ready_and), gexp);
    end

    @(posedge clk);
    if (rst_n) begin
      if (e_yumi) void'(q.pop_front());
      if (e_cv && rdy) begin
        q.push_back(w);
        ptr = (w + 1) % N;
      end
`ifdef BP_ME_MEM_ARB_ERR_CHECK_EN
      if (rv && was_empty) err_m = 1'b1;
`endif
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    // Handshakes held at zero during reset even with both requesters valid.
    rst_n = 1'b0;
    reset_model();
    apply(2'b11, 1'b1, 1'b0, 2'b00, -1);
    apply(2'b11, 1'b1, 1'b0, 2'b00, -1);
    rst_n = 1'b1;

    apply(2'b11, 1'b1, 1'b0, 2'b00, 0);
    apply(2'b11, 1'b1, 1'b0, 2'b00, 1);
    apply(2'b11, 1'b1, 1'b0, 2'b00, 0);
    apply(2'b11, 1'b1, 1'b0, 2'b00, 1);
    for (int i = 0; i < 8 && have(); i++) apply(2'b00, 1'b1, 1'b1, owner_mask(), -1);

    // Requester 1 alone, then an idle cycle, then both.
    apply(2'b10, 1'b1, have(), owner_mask(), 1);
    apply(2'b10, 1'b1, have(), owner_mask(), 1);
    apply(2'b10, 1'b1, have(), owner_mask(), 1);
    apply(2'b00, 1'b1, have(), owner_mask(), -1);
    apply(2'b11, 1'b1, have(), owner_mask(), 0);
    apply(2'b11, 1'b1, have(), owner_mask(), 1);
    for (int i = 0; i < 8 && have(); i++) apply(2'b00, 1'b1, 1'b1, owner_mask(), -1);

    // Fill the FIFO with no responses; a pop on the full cycle does not grant.
    for (int i = 0; i < 4; i++) apply(2'b11, 1'b1, 1'b0, 2'b00, -2);
    apply(2'b11, 1'b1, 1'b0, 2'b00, -1);
    apply(2'b11, 1'b1, 1'b0, 2'b00, -1);
    apply(2'b11, 1'b1, 1'b1, owner_mask(), -1);
    apply(2'b11, 1'b1, 1'b0, 2'b00, -2);
    check("full_regrant", 32'(q.size()), 32'd4);
    for (int i = 0; i < 8 && have(); i++) apply(2'b00, 1'b1, 1'b1, owner_mask(), -1);

    // Grants 0,1,1,0 and in-order routing with a slow requester 1.
    rst_n = 1'b0;
    reset_model();
    apply(2'b11, 1'b1, 1'b1, 2'b00, -1);
    rst_n = 1'b1;
    apply(2'b01, 1'b1, 1'b0, 2'b00, 0);
    apply(2'b10, 1'b1, 1'b0, 2'b00, 1);
    apply(2'b10, 1'b1, 1'b0, 2'b00, 1);
    apply(2'b01, 1'b1, 1'b0, 2'b00, 0);
    apply(2'b00, 1'b1, 1'b1, owner_mask(), -1);
`ifndef BP_ME_MEM_ARB_ERR_CHECK_EN
    apply(2'b00, 1'b1, 1'b1, 2'b01, -1);
`endif
    for (int i = 0; i < 5; i++) apply(2'b00, 1'b1, 1'b1, 2'b00, -1);
    apply(2'b00, 1'b1, 1'b1, owner_mask(), -1);
    apply(2'b00, 1'b1, 1'b1, owner_mask(), -1);
    apply(2'b00, 1'b1, 1'b1, owner_mask(), -1);
    check("drained", 32'(q.size()), 32'd0);

    // Response with nothing outstanding.
    apply(2'b00, 1'b0, 1'b1, 2'b00, -1);
    apply(2'b00, 1'b0, 1'b0, 2'b00, -1);
    apply(2'b00, 1'b0, 1'b0, 2'b00, -1);

    // Reset with three commands outstanding.
    apply(2'b11, 1'b1, 1'b0, 2'b00, -2);
    apply(2'b11, 1'b1, 1'b0, 2'b00, -2);
    apply(2'b11, 1'b1, 1'b0, 2'b00, -2);
    rst_n = 1'b0;
    reset_model();
    apply(2'b11, 1'b1, 1'b1, 2'b00, -1);
    apply(2'b11, 1'b1, 1'b1, 2'b00, -1);
    rst_n = 1'b1;
    apply(2'b11, 1'b1, 1'b1, 2'b00, 0);
    apply(2'b00, 1'b1, 1'b1, owner_mask(), -1);

    // Random traffic; responses only while something is outstanding.
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] cv;
      logic rdy, rv, ack;
      cv  = N'($urandom_range(0, (1 << N) - 1));
      rdy = 1'($urandom_range(0, 3) != 0);
      rv  = have() && ($urandom_range(0, 2) != 0);
      ack = 1'($urandom_range(0, 1));
      apply(cv, rdy, rv, ack ? owner_mask() : '0, -2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bp_me_mem_cmd_arbiter.md
# bp_me_mem_cmd_arbiter

Round-robin arbiter that shares one BedRock memory command/response port, such as the `bp_mem` port behind the I$ wrapper, among `num_req_p` cache-side requesters (I$, D$, uncached engine).
- Commands are granted in the same cycle they win arbitration.
- The requester index of every accepted command is pushed into an in-order ID FIFO.
- Memory responses, which return in command order, are routed back to the requester at the FIFO head.
- The block sits between the cache engines and the memory model in subsystem testbenches and in the unicore ME.

## Interface
Parameters:
- `num_req_p`, 2: number of requesters; legal range 2..8.
- `msg_width_p`, none: width of the packed `bp_bedrock_cce_mem_msg_s` (header plus data).
- `id_fifo_els_p`, 4: maximum outstanding commands; must be a power of 2, range 2..16.

Ports (clock and reset first):
- `clk_i` in 1: clock. All state updates on the rising edge.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `req_cmd_i` in `num_req_p*msg_width_p`: requester commands; slot i is at `[i*msg_width_p +: msg_width_p]`.
- `req_cmd_v_i` in `num_req_p`: per-requester command valid.
- `req_cmd_ready_and_o` out `num_req_p`: per-requester command accepted (one-hot or zero).
- `req_resp_o` out `msg_width_p`: response payload, broadcast to all requesters.
- `req_resp_v_o` out `num_req_p`: response valid, one-hot to the owning requester.
- `req_resp_yumi_i` in `num_req_p`: response consumed by a requester.
- `mem_cmd_o` out `msg_width_p`: granted command.
- `mem_cmd_v_o` out 1: granted command valid.
- `mem_cmd_ready_and_i` in 1: memory accepts the command.
- `mem_resp_i` in `msg_width_p`: memory response.
- `mem_resp_v_i` in 1: memory response valid.
- `mem_resp_yumi_o` out 1: memory response consumed.
- `error_o` out 1: sticky protocol-error flag.

## Operation
- State:
  - `rr_ptr_r`: `$clog2(num_req_p)` bits, the highest-priority index.
  - ID FIFO: `id_fifo_els_p` entries of `$clog2(num_req_p)` bits, with read/write pointers and a count of width `$clog2(id_fifo_els_p)+1`.
  - `error_r`.
- Arbitration:
  - Scan `req_cmd_v_i` starting at `rr_ptr_r`, wrapping modulo `num_req_p`; the first set bit is the winner `w`.
  - Arbitration is suppressed while the FIFO is full.
- Command path (combinational):
  - `mem_cmd_v_o = |req_cmd_v_i & ~fifo_full`.
  - `mem_cmd_o` = slot `w`.
  - `req_cmd_ready_and_o[w] = mem_cmd_v_o & mem_cmd_ready_and_i`; all other bits are 0.
  - A command is accepted when `mem_cmd_v_o & mem_cmd_ready_and_i`. On accept:
    - push `w` into the FIFO;
    - set `rr_ptr_r <= (w == num_req_p-1) ? 0 : w+1`.
  - `rr_ptr_r` is unchanged on cycles without an accept.
- Response path:
  - `h` = FIFO head.
  - `req_resp_v_o[h] = mem_resp_v_i & ~fifo_empty`; all other bits are 0.
  - `req_resp_o = mem_resp_i`.
  - `mem_resp_yumi_o = req_resp_yumi_i[h] & req_resp_v_o[h]`.
  - The FIFO pops when `mem_resp_yumi_o` is asserted.
- Boundary conditions:
  - **FIFO full:** no grant, even if a pop occurs in the same cycle. The full flag is registered state, not a bypass.
  - **FIFO empty with `mem_resp_v_i` high:** the response is never consumed, `mem_resp_yumi_o` = 0, and `error_r` is set (see Configuration).
  - **Push and pop in the same cycle:** allowed when not full; the count is unchanged and the pointers wrap modulo `id_fifo_els_p`.
  - **Yumi from a non-owner requester:** ignored.
- Reset, while `reset_n_i` is low or when it asserts mid-transfer:
  - `rr_ptr_r` = 0, FIFO empty, `error_r` = 0.
  - `mem_cmd_v_o`, `req_cmd_ready_and_o`, `req_resp_v_o` and `mem_resp_yumi_o` are all forced to 0.
  - Outstanding IDs are discarded; memory must also be reset.

## Timing
- Command: zero-cycle latency from `req_cmd_v_i` to `mem_cmd_v_o`. There is no registered stage.
- Response: zero-cycle latency from `mem_resp_v_i` to `req_resp_v_o`.
- A new grant can be made every cycle; sustained throughput is 1 command/cycle while the FIFO is not full.
- FIFO pointer, count and `rr_ptr_r` updates are visible the cycle after the handshake.
- `error_o` rises the cycle after the offending condition and holds until reset.
- Requesters must not make `req_cmd_v_i` depend combinationally on `req_cmd_ready_and_o`.

## Configuration
- Macro: `BP_ME_MEM_ARB_ERR_CHECK_EN`.
- **Defined:**
  - `error_r` is implemented as described in Operation.
  - The simulation `$error` fires on an unowned response.
  - The simulation `$error` fires on any `req_resp_yumi_i` bit outside `req_resp_v_o`.
- **Undefined:**
  - `error_o` is tied to 0 and no checking logic is generated.
  - Unowned responses still stall (`mem_resp_yumi_o` = 0).

## Test plan
- Reset with `num_req_p`=2 and both valids held high -> all handshake outputs are 0 while reset is asserted. After release, grants alternate 0,1,0,1 with `mem_cmd_ready_and_i`=1.
- Only requester 1 valid for 3 cycles, then both valid -> grants are 1,1,1, then 0, then 1. `rr_ptr_r` does not advance on idle cycles.
- `id_fifo_els_p`=4, memory never responds, both requesters valid -> exactly 4 accepts, then `mem_cmd_v_o`=0.
  - A single response then pops, and a grant occurs the next cycle, not the same cycle.
- Commands granted in order 0,1,1,0, with responses returned in order -> `req_resp_v_o` sequence is 01,10,10,01 (one-hot). With requester 1 yumi delayed 5 cycles, `mem_resp_yumi_o` stays 0 until it arrives.
- `mem_resp_v_i`=1 with an empty FIFO:
  - with the macro defined -> `error_o`=1 the next cycle and sticky;
  - without the macro -> `error_o`=0;
  - in both cases `mem_resp_yumi_o`=0.
- Reset asserted mid-stream with 3 outstanding -> after release, FIFO is empty, the first grant goes to requester 0, and no `req_resp_v_o` fires for stale IDs.
